// File: rtl/mult_div_unit.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Optional MTHI/MTLO write ports are enabled by defining MDU_MOVE_EN.
`timescale 1ns/1ps
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
`ifdef MDU_MOVE_EN
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] move_data,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic             is_div;
   logic             sign_a;
   logic             sign_b;
   logic             dz;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [2*WIDTH-1:0] acc;

   // operand decode at start
   logic             in_signed;
   logic             in_div;
   logic             in_neg_a;
   logic             in_neg_b;
   logic [WIDTH-1:0] in_abs_a;
   logic [WIDTH-1:0] in_abs_b;

   assign in_signed = ~op[0];
   assign in_div    = op[1];
   assign in_neg_a  = in_signed & operand_a[WIDTH-1];
   assign in_neg_b  = in_signed & operand_b[WIDTH-1];
   assign in_abs_a  = in_neg_a ? -operand_a : operand_a;
   assign in_abs_b  = in_neg_b ? -operand_b : operand_b;

   // multiply step: multiplier sits in acc low half and shifts out as the product shifts in
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, abs_a})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // restoring divide step: acc = {remainder, dividend/quotient}
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;

   assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, abs_b};
   assign div_ge   = div_sh >= {1'b0, abs_b};
   assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};

   // sign correction; sign_a/sign_b are only ever set for signed ops
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   raw_a;

   assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
   assign quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   assign raw_a    = sign_a ? -abs_a : abs_a;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         dz     <= 1'b0;
         abs_a  <= '0;
         abs_b  <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div <= in_div;
                  sign_a <= in_neg_a;
                  sign_b <= in_neg_b;
                  abs_a  <= in_abs_a;
                  abs_b  <= in_abs_b;
                  acc    <= {{WIDTH{1'b0}}, (in_div ? in_abs_a : in_abs_b)};
                  count  <= '0;
                  busy   <= 1'b1;
                  if (in_div && operand_b == '0) begin
                     dz    <= 1'b1;
                     state <= FIX;
                  end else begin
                     dz    <= 1'b0;
                     state <= CALC;
                  end
               end
`ifdef MDU_MOVE_EN
               else begin
                  if (mthi) hi <= move_data;
                  if (mtlo) lo <= move_data;
               end
`endif
            end
            CALC: begin
               acc   <= is_div ? div_next : mul_next;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               if (dz) begin
                  hi <= raw_a;
                  lo <= '1;
               end else if (is_div) begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, busy window, results and reset abort.
`timescale 1ns/1ps
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Issue one operation from IDLE and check latency, busy window and result.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
      int n;
      int busy_n;
      logic seen;
      op = o; operand_a = a; operand_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; busy_n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         if (busy) busy_n++;
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy_cycles"}, busy_n, lat);
      check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, hi, eh);
      check({tag, "_lo"}, lo, el);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_hi_hold"}, hi, eh);
      check({tag, "_lo_hold"}, lo, el);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
      @(posedge clk); #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
      do_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      do_op("mult_minsq", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33);
      do_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      do_op("div_negb",   OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
      do_op("divu",       OP_DIVU,  32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 33);
      do_op("divu_zero",  OP_DIVU,  32'd100,      32'd0,        32'd100,       32'hFFFF_FFFF, 1);
      do_op("div_zero",   OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
      do_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);

      // start while busy is ignored: first result stands, latency unchanged
      op = OP_MULT; operand_a = 32'd5; operand_b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      operand_a = 32'd9; operand_b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         int n;
         n = 5;
         while (!done && n < 45) begin @(posedge clk); #1; n++; end
         check("busy_start_latency", n, 33);
         check("busy_start_lo", lo, 32'd30);
         check("busy_start_hi", hi, 32'd0);
      end
      @(posedge clk); #1;
      check("busy_start_no_second", {31'd0, busy}, 32'd0);

      // reset mid-operation aborts and clears hi/lo
      do_op("pre_abort", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33);
      op = OP_MULT; operand_a = 32'd5; operand_b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      operand_a = 32'd9; operand_b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #2;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_idle_hi", hi, 32'd0);
      check("abort_idle_lo", lo, 32'd0);
      do_op("after_abort", OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
